iterative_shift_controller: RTL and testbench

Multi-cycle controller that sequences the fixed-amount shift stages (16, 8, 4, 2, 1) of the ALU barrel shifter. It applies one stage per clock to a latched operand, so any 0–31 bit shift is built from a single shared stage datapath instead of five cascaded combinational stages. The block sits beside the 32-bit ALU and serves SLL, SRL and SRA through a start/done handshake.

---
 rtl/iterative_shift_controller_pkg.sv | 27 ++
 rtl/iterative_shift_controller_if.sv | 24 ++
 rtl/iterative_shift_controller_shift_stage.sv | 27 ++
 rtl/iterative_shift_controller.sv | 91 +++++++++
 tb/tb_iterative_shift_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/iterative_shift_controller_pkg.sv
// Shared types and constants for the iterative shift controller: FSM state
// encoding, stage ordering, direction encoding and the stage-amount helper.
package iterative_shift_controller_pkg;

  localparam int WIDTH     = 32;  // the 16/8/4/2/1 stage set only covers a 32-bit operand
  localparam int SHAMT_W   = 5;

  typedef logic [2:0] stage_idx_t;

  localparam stage_idx_t STAGE_FIRST = 3'd4;  // 16-bit stage
  localparam stage_idx_t STAGE_LAST  = 3'd0;  // 1-bit stage

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Shift distance of stage k is 2^k.
  function automatic logic [SHAMT_W-1:0] stage_amount(input stage_idx_t k);
    return SHAMT_W'(1) << k;
  endfunction

endpackage

// File: rtl/iterative_shift_controller_if.sv
// Start/done request bus between the ALU sequencer (master) and the shift controller (slave).
interface iterative_shift_controller_if;
  import iterative_shift_controller_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               dir;
  logic               arith;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, data_in, shamt, dir, arith,
    input  busy, done, result
  );

  modport slave (
    input  start, data_in, shamt, dir, arith,
    output busy, done, result
  );

endinterface

// File: rtl/iterative_shift_controller_shift_stage.sv
// One combinational barrel-shifter stage: shifts by 2^k left, right logical
// or right arithmetic. Shared by every step of the iterative controller.
module shift_stage
  import iterative_shift_controller_pkg::*;
(
  input  logic [WIDTH-1:0] i_value,
  input  stage_idx_t       i_k,
  input  logic             i_dir,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_value
);

  logic        [SHAMT_W-1:0] w_amt;
  logic        [WIDTH-1:0]   w_sll;
  logic        [WIDTH-1:0]   w_srl;
  logic signed [WIDTH-1:0]   w_sra;

  assign w_amt = stage_amount(i_k);
  assign w_sll = i_value << w_amt;
  assign w_srl = i_value >> w_amt;
  // Kept in its own signed net: inside a mixed-sign ?: the >>> would turn logical.
  assign w_sra = $signed(i_value) >>> w_amt;

  assign o_value = (i_dir == DIR_LEFT) ? w_sll
                 : (i_arith ? $unsigned(w_sra) : w_srl);

endmodule

// File: rtl/iterative_shift_controller.sv
// Multi-cycle SLL/SRL/SRA engine: latches an operand on start, applies the
// 16/8/4/2/1 stages one per clock through a single shift_stage, pulses done.
module iterative_shift_controller
  import iterative_shift_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  iterative_shift_controller_if.slave   bus
);

  state_e             r_state,  w_state_nxt;
  stage_idx_t         r_stage_idx, w_stage_idx_nxt;
  logic [WIDTH-1:0]   r_work,   w_work_nxt;
  logic [SHAMT_W-1:0] r_shamt,  w_shamt_nxt;
  logic               r_dir,    w_dir_nxt;
  logic               r_arith,  w_arith_nxt;
  logic [WIDTH-1:0]   w_stage_out;

  shift_stage u_stage (
    .i_value (r_work),
    .i_k     (r_stage_idx),
    .i_dir   (r_dir),
    .i_arith (r_arith),
    .o_value (w_stage_out)
  );

  // NOTE: every register, operand latches included, is reset so that an
  // aborted operation leaves nothing behind and result reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_stage_idx <= '0;
      r_work      <= '0;
      r_shamt     <= '0;
      r_dir       <= 1'b0;
      r_arith     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state     <= w_state_nxt;
      r_stage_idx <= w_stage_idx_nxt;
      r_work      <= w_work_nxt;
      r_shamt     <= w_shamt_nxt;
      r_dir       <= w_dir_nxt;
      r_arith     <= w_arith_nxt;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first; any path that skips one would infer a latch.
    w_state_nxt     = r_state;
    w_stage_idx_nxt = r_stage_idx;
    w_work_nxt      = r_work;
    w_shamt_nxt     = r_shamt;
    w_dir_nxt       = r_dir;
    w_arith_nxt     = r_arith;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt     = ST_SHIFT;
          w_stage_idx_nxt = STAGE_FIRST;
          w_work_nxt      = bus.data_in;
          w_shamt_nxt     = bus.shamt;
          w_dir_nxt       = bus.dir;
          w_arith_nxt     = bus.arith;
        end
      end
      ST_SHIFT: begin
        if (r_shamt[r_stage_idx]) begin
          w_work_nxt = w_stage_out;
        end
        if (r_stage_idx == STAGE_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_stage_idx_nxt = r_stage_idx - 3'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_work;

endmodule

// File: tb/tb_iterative_shift_controller.sv
// Scoreboard bench for iterative_shift_controller: directed operations push
// hand-computed results; a negedge monitor pops and checks on every done.
module tb_iterative_shift_controller;
  import iterative_shift_controller_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        dir;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  iterative_shift_controller_if bus ();

  iterative_shift_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on done, checks latency, busy width and done spacing.
  logic prev_done;
  int   busy_run;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_done = 1'b0;
      busy_run  = 0;
    end else begin
      if (bus.done) begin
        check("done_not_back_to_back", 32'(prev_done), 32'd0);
        check("busy_with_done", 32'(bus.busy), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("done_latency", 32'(cyc), 32'(e.done_cyc));
        end
      end
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_cycles", 32'(busy_run), 32'd6);
        busy_run = 0;
      end
      prev_done = bus.done;
    end
  end

  // Drive one operation at a negedge; the next posedge is its acceptance edge
  // and done must be observed at the negedge five edges after that.
  task automatic issue(input vec_t v, input bit push);
    bus.start   = 1'b1;
    bus.data_in = v.data;
    bus.shamt   = v.shamt;
    bus.dir     = v.dir;
    bus.arith   = v.arith;
    if (push) begin
      exp_t e;
      e.res      = v.exp;
      e.done_cyc = cyc + 6;
      sb.push_back(e);
    end
  endtask

  task automatic scramble();
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom);
    bus.dir     = 1'($urandom);
    bus.arith   = 1'($urandom);
  endtask

  task automatic run_op(input vec_t v, input string name);
    @(negedge clk);
    issue(v, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    repeat (8) @(negedge clk);
    check({name, "_held"}, bus.result, v.exp);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  vec_t vecs[12];
  vec_t held[3];

  initial begin
    vecs[0]  = '{32'hFFFF0000, 5'd16, DIR_RIGHT, 1'b0, 32'h0000FFFF};
    vecs[1]  = '{32'hFFFF0000, 5'd16, DIR_RIGHT, 1'b1, 32'hFFFFFFFF};
    vecs[2]  = '{32'h80000000, 5'd31, DIR_RIGHT, 1'b1, 32'hFFFFFFFF};
    vecs[3]  = '{32'h80000000, 5'd31, DIR_RIGHT, 1'b0, 32'h00000001};
    vecs[4]  = '{32'hF0000000, 5'd21, DIR_RIGHT, 1'b1, 32'hFFFFFF80};
    vecs[5]  = '{32'h0000FFFF, 5'd16, DIR_LEFT,  1'b1, 32'hFFFF0000};
    vecs[6]  = '{32'h00000001, 5'd31, DIR_LEFT,  1'b0, 32'h80000000};
    vecs[7]  = '{32'h12345678, 5'd0,  DIR_RIGHT, 1'b1, 32'h12345678};
    vecs[8]  = '{32'h12345678, 5'd4,  DIR_LEFT,  1'b0, 32'h23456780};
    vecs[9]  = '{32'h87654321, 5'd8,  DIR_RIGHT, 1'b0, 32'h00876543};
    vecs[10] = '{32'h87654321, 5'd12, DIR_RIGHT, 1'b1, 32'hFFF87654};
    vecs[11] = '{32'hA5A5A5A5, 5'd1,  DIR_LEFT,  1'b0, 32'h4B4B4B4A};

    held[0]  = '{32'hC0000003, 5'd1,  DIR_RIGHT, 1'b1, 32'hE0000001};
    held[1]  = '{32'h0000000F, 5'd28, DIR_LEFT,  1'b0, 32'hF0000000};
    held[2]  = '{32'hDEADBEEF, 5'd5,  DIR_RIGHT, 1'b0, 32'h06F56DF7};

    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    bus.dir     = 1'b0;
    bus.arith   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_done",   32'(bus.done), 32'd0);
    check("reset_result", bus.result,    32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // start held high throughout; operands change every cycle outside acceptance
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(held[i], 1'b1);
      repeat (6) begin
        @(negedge clk);
        scramble();
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_result_last", bus.result, held[2].exp);

    // abort mid-operation: reset right after the third stage edge
    @(negedge clk);
    issue(vecs[1], 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus.busy), 32'd0);
    check("abort_done",   32'(bus.done), 32'd0);
    check("abort_result", bus.result,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[10], "after_abort");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
